// File: rtl/cache_pkg.sv
// Shared widths, FSM state type and address field helpers for the cache controller.
package cache_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 11;
  localparam int TAG_W  = 19;
  localparam int OFF_W  = 2;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, REFILL} state_t;

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  // Memory only ever sees whole-block addresses, so the offset is zeroed.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_ctrl_lru.sv
// Per-set LRU bit store: one bit per set, 1 means way1 is least recently used.
module lru_array
  import cache_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_bit,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic             wr_bit
);
  logic [(1<<IDX_W)-1:0] bits;

  assign rd_bit = bits[rd_index];

  // Reset makes way0 the LRU way in every set.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bits <= '0;
    end else if (wr_en) begin
      bits[wr_index] <= wr_bit;
    end
  end
endmodule

// File: rtl/cache_ctrl.sv
// Write-back / write-allocate sequencing for a 2-way, 1-word-block cache.
//
// state  | meaning
// IDLE   | waiting for a CPU request; request fields are latched on accept
// LOOKUP | arrays indexed by the request; hit completes, miss picks a victim
// WB     | writing the dirty victim back to memory
// REFILL | reading the requested block and installing it in the victim way
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [IDX_W-1:0]  dp_index,
  input  logic              dp_hit0,
  input  logic              dp_hit1,
  input  logic              dp_valid0,
  input  logic              dp_valid1,
  input  logic              dp_dirty0,
  input  logic              dp_dirty1,
  input  logic [TAG_W-1:0]  dp_tag0,
  input  logic [TAG_W-1:0]  dp_tag1,
  input  logic [DATA_W-1:0] dp_rdata0,
  input  logic [DATA_W-1:0] dp_rdata1,
  output logic              dp_we,
  output logic              dp_way,
  output logic [TAG_W-1:0]  dp_wtag,
  output logic [DATA_W-1:0] dp_wdata,
  output logic              dp_wdirty,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t            state, state_nxt;
  logic              req_we;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] req_wdata;
  logic              vic_way;
  logic [TAG_W-1:0]  vic_tag;
  logic [DATA_W-1:0] vic_data;
  logic              hit, hit_way;
  logic              miss_way, miss_dirty;
  logic              lru_bit, lru_we, lru_wbit;
  logic              unused_off;

  // Byte offset carries no information for a one-word block.
  assign unused_off = ^cpu_addr[OFF_W-1:0];

  // A double hit is resolved as a way0 hit.
  assign hit      = dp_hit0 | dp_hit1;
  assign hit_way  = ~dp_hit0;
  assign dp_index = req_idx;

  lru_array u_lru (
    .CLK      (CLK),
    .RESET    (RESET),
    .rd_index (req_idx),
    .rd_bit   (lru_bit),
    .wr_en    (lru_we),
    .wr_index (req_idx),
    .wr_bit   (lru_wbit)
  );

  // Victim choice: an invalid way first (way0 preferred), otherwise the LRU way.
  always_comb begin
    if (!dp_valid0) begin
      miss_way = 1'b0;
    end else if (!dp_valid1) begin
      miss_way = 1'b1;
    end else begin
      miss_way = lru_bit;
    end
    miss_dirty = miss_way ? (dp_valid1 & dp_dirty1) : (dp_valid0 & dp_dirty0);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request and victim capture registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      req_we    <= 1'b0;
      req_tag   <= '0;
      req_idx   <= '0;
      req_wdata <= '0;
      vic_way   <= 1'b0;
      vic_tag   <= '0;
      vic_data  <= '0;
    end else begin
      if (state == IDLE && cpu_req) begin
        req_we    <= cpu_we;
        req_tag   <= addr_tag(cpu_addr);
        req_idx   <= addr_index(cpu_addr);
        req_wdata <= cpu_wdata;
      end
      if (state == LOOKUP && !hit) begin
        vic_way  <= miss_way;
        vic_tag  <= miss_way ? dp_tag1 : dp_tag0;
        vic_data <= miss_way ? dp_rdata1 : dp_rdata0;
      end
    end
  end

  // Next state and output decode.
  always_comb begin
    state_nxt = state;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    dp_we     = 1'b0;
    dp_way    = 1'b0;
    dp_wtag   = '0;
    dp_wdata  = '0;
    dp_wdirty = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    lru_we    = 1'b0;
    lru_wbit  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          cpu_ready = 1'b1;
          lru_we    = 1'b1;
          lru_wbit  = ~hit_way;
          state_nxt = IDLE;
          if (req_we) begin
            dp_we     = 1'b1;
            dp_way    = hit_way;
            dp_wtag   = hit_way ? dp_tag1 : dp_tag0;
            dp_wdata  = req_wdata;
            dp_wdirty = 1'b1;
          end else begin
            cpu_rdata = hit_way ? dp_rdata1 : dp_rdata0;
          end
        end else begin
          state_nxt = miss_dirty ? WB : REFILL;
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = line_addr(vic_tag, req_idx);
        mem_wdata = vic_data;
        if (mem_ack) state_nxt = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = line_addr(req_tag, req_idx);
        if (mem_ack) begin
          dp_we     = 1'b1;
          dp_way    = vic_way;
          dp_wtag   = req_tag;
          dp_wdata  = req_we ? req_wdata : mem_rdata;
          dp_wdirty = req_we;
          state_nxt = LOOKUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: emulates the tag/data arrays and main memory, and checks
// every access against a recency-list cache model over a flat memory image.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic [10:0] dp_index;
  logic        dp_hit0, dp_hit1, dp_valid0, dp_valid1, dp_dirty0, dp_dirty1;
  logic [18:0] dp_tag0, dp_tag1;
  logic [31:0] dp_rdata0, dp_rdata1;
  logic        dp_we, dp_way, dp_wdirty;
  logic [18:0] dp_wtag;
  logic [31:0] dp_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  cache_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dp_index(dp_index),
    .dp_hit0(dp_hit0), .dp_hit1(dp_hit1), .dp_valid0(dp_valid0), .dp_valid1(dp_valid1),
    .dp_dirty0(dp_dirty0), .dp_dirty1(dp_dirty1), .dp_tag0(dp_tag0), .dp_tag1(dp_tag1),
    .dp_rdata0(dp_rdata0), .dp_rdata1(dp_rdata1),
    .dp_we(dp_we), .dp_way(dp_way), .dp_wtag(dp_wtag), .dp_wdata(dp_wdata), .dp_wdirty(dp_wdirty),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Datapath array emulation (not reset by the controller)
  logic        dp_clear = 1'b1;
  logic        a_valid [2][2048];
  logic        a_dirty [2][2048];
  logic [18:0] a_tag   [2][2048];
  logic [31:0] a_data  [2][2048];

  always @(posedge CLK) begin
    if (dp_clear) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 2048; s++) begin
          a_valid[w][s] <= 1'b0;
          a_dirty[w][s] <= 1'b0;
        end
    end else if (dp_we) begin
      a_valid[dp_way][dp_index] <= 1'b1;
      a_dirty[dp_way][dp_index] <= dp_wdirty;
      a_tag[dp_way][dp_index]   <= dp_wtag;
      a_data[dp_way][dp_index]  <= dp_wdata;
    end
  end

  assign dp_valid0 = a_valid[0][dp_index];
  assign dp_valid1 = a_valid[1][dp_index];
  assign dp_dirty0 = a_dirty[0][dp_index];
  assign dp_dirty1 = a_dirty[1][dp_index];
  assign dp_tag0   = a_tag[0][dp_index];
  assign dp_tag1   = a_tag[1][dp_index];
  assign dp_rdata0 = a_data[0][dp_index];
  assign dp_rdata1 = a_data[1][dp_index];
  assign dp_hit0   = a_valid[0][dp_index] && (a_tag[0][dp_index] == cpu_addr[31:13]);
  assign dp_hit1   = a_valid[1][dp_index] && (a_tag[1][dp_index] == cpu_addr[31:13]);

  // Main memory contents (bm) and the architectural memory image the CPU should see (fm)
  logic [31:0] bm [logic [31:0]];
  logic [31:0] fm [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] bm_rd(input logic [31:0] a);
    if (bm.exists(a)) return bm[a];
    return dflt(a);
  endfunction
  function automatic logic [31:0] fm_rd(input logic [31:0] a);
    if (fm.exists(a)) return fm[a];
    return dflt(a);
  endfunction

  // Reference cache: per set, resident lines ordered most-recent first
  typedef struct packed {
    logic [18:0] tag;
    logic        way;
    logic        dirty;
  } line_t;
  line_t rset [2048][$];

  // One CPU access; called and returns at a falling edge.
  task automatic run_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int ack_delay);
    logic [10:0] idx;
    logic [18:0] tag;
    logic [31:0] line, exp_rdata;
    bit          hit, hway, vway;
    int          pos, exp_n, exp_wn;
    bit          e_we [2];
    logic [31:0] e_addr [2];
    logic [31:0] e_data [2];
    bit          w_way [2];
    logic [18:0] w_tag [2];
    logic [31:0] w_data [2];
    bit          w_dirty [2];
    int          n_txn, n_wr, wait_cnt, last_ack_c, exp_c;
    bit          done, prev_req, prev_ack, prev_we;
    logic [31:0] prev_addr, prev_wdata;
    line_t       ent;

    idx = addr[12:2];
    tag = addr[31:13];
    line = {addr[31:2], 2'b00};
    hit = 0; hway = 0; vway = 0; pos = -1; exp_n = 0; exp_wn = 0;
    for (int i = 0; i < rset[idx].size(); i++)
      if (rset[idx][i].tag == tag) begin hit = 1; hway = rset[idx][i].way; pos = i; end
    exp_rdata = fm_rd(line);
    if (hit) begin
      ent = rset[idx][pos];
      rset[idx].delete(pos);
      ent.dirty = ent.dirty | we;
      if (we) begin
        w_way[0] = hway; w_tag[0] = tag; w_data[0] = wdata; w_dirty[0] = 1; exp_wn = 1;
      end
    end else begin
      if (rset[idx].size() == 2) begin
        ent = rset[idx].pop_back();
        vway = ent.way;
        if (ent.dirty) begin
          e_we[0] = 1; e_addr[0] = {ent.tag, idx, 2'b00}; e_data[0] = fm_rd(e_addr[0]); exp_n = 1;
        end
      end else begin
        vway = (rset[idx].size() == 1 && rset[idx][0].way == 1'b0);
      end
      e_we[exp_n] = 0; e_addr[exp_n] = line; e_data[exp_n] = '0; exp_n++;
      w_way[0] = vway; w_tag[0] = tag; w_data[0] = we ? wdata : fm_rd(line); w_dirty[0] = we;
      exp_wn = 1;
      if (we) begin
        w_way[1] = vway; w_tag[1] = tag; w_data[1] = wdata; w_dirty[1] = 1; exp_wn = 2;
      end
      ent.tag = tag; ent.way = vway; ent.dirty = we;
    end
    rset[idx].push_front(ent);
    if (we) fm[line] = wdata;

    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; mem_ack = 0;
    n_txn = 0; n_wr = 0; wait_cnt = 0; last_ack_c = 0; done = 0;
    prev_req = 0; prev_ack = 0; prev_we = 0; prev_addr = '0; prev_wdata = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) @(negedge CLK);
      mem_ack = 0;
      #1;
      if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1; mem_rdata = bm_rd(mem_addr); wait_cnt = 0;
          #1;
        end else begin
          wait_cnt++;
        end
      end
      if (prev_req && !prev_ack && mem_req) begin
        vectors++;
        if ({mem_we, mem_addr, mem_wdata} !== {prev_we, prev_addr, prev_wdata}) begin
          miscompares++;
          $display("FAIL mem_stable @%h: got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                   addr, mem_we, mem_addr, mem_wdata, prev_we, prev_addr, prev_wdata);
        end
      end
      if (mem_req) begin
        vectors++;
        if (cpu_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL ready_during_mem @%h: got %b want 0", addr, cpu_ready);
        end
      end
      if (mem_ack) begin
        vectors++;
        if (n_txn >= exp_n) begin
          miscompares++;
          $display("FAIL mem_txn_extra @%h: got we=%b addr=%h want no transaction", addr, mem_we, mem_addr);
        end else if (mem_we !== e_we[n_txn] || mem_addr !== e_addr[n_txn] ||
                     (e_we[n_txn] && mem_wdata !== e_data[n_txn])) begin
          miscompares++;
          $display("FAIL mem_txn @%h: got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                   addr, mem_we, mem_addr, mem_wdata, e_we[n_txn], e_addr[n_txn], e_data[n_txn]);
        end
        if (mem_we) bm[mem_addr] = mem_wdata;
        last_ack_c = c;
        n_txn++;
      end
      if (dp_we) begin
        vectors++;
        if (n_wr >= exp_wn) begin
          miscompares++;
          $display("FAIL dp_write_extra @%h: got way=%b tag=%h want no write", addr, dp_way, dp_wtag);
        end else if (dp_way !== w_way[n_wr] || dp_wtag !== w_tag[n_wr] ||
                     dp_wdata !== w_data[n_wr] || dp_wdirty !== w_dirty[n_wr]) begin
          miscompares++;
          $display("FAIL dp_write @%h: got way=%b tag=%h data=%h dirty=%b want way=%b tag=%h data=%h dirty=%b",
                   addr, dp_way, dp_wtag, dp_wdata, dp_wdirty,
                   w_way[n_wr], w_tag[n_wr], w_data[n_wr], w_dirty[n_wr]);
        end
        n_wr++;
      end
      if (cpu_ready) begin
        done = 1;
        exp_c = hit ? 1 : last_ack_c + 1;
        vectors++;
        if (c != exp_c) begin
          miscompares++;
          $display("FAIL ready_latency @%h: got cycle %0d want cycle %0d", addr, c, exp_c);
        end
        if (!we) begin
          vectors++;
          if (cpu_rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL load_data @%h: got %h want %h", addr, cpu_rdata, exp_rdata);
          end
        end
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_we = mem_we;
      prev_addr = mem_addr; prev_wdata = mem_wdata;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL access_timeout @%h: got no cpu_ready in 200 cycles want completion", addr);
    end
    vectors++;
    if (n_txn != exp_n || n_wr != exp_wn) begin
      miscompares++;
      $display("FAIL access_counts @%h: got txns=%0d writes=%0d want txns=%0d writes=%0d",
               addr, n_txn, n_wr, exp_n, exp_wn);
    end
    @(negedge CLK);
    cpu_req = 0; mem_ack = 0;
  endtask

  task automatic test_reset();
    RESET = 1; dp_clear = 1;
    repeat (3) @(negedge CLK);
    RESET = 0; dp_clear = 0;
    #1;
    vectors++;
    if ({cpu_ready, dp_we, mem_req, mem_we} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ready=%b dp_we=%b mem_req=%b mem_we=%b want 0000",
               cpu_ready, dp_we, mem_req, mem_we);
    end
    vectors++;
    if (mem_addr !== '0 || mem_wdata !== '0 || cpu_rdata !== '0 || dp_index !== '0 || dp_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got mem_addr=%h mem_wdata=%h rdata=%h index=%h wdata=%h want zeros",
               mem_addr, mem_wdata, cpu_rdata, dp_index, dp_wdata);
    end
    @(negedge CLK);
    mem_ack = 1;
    #1;
    vectors++;
    if (dp_we !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ack: got dp_we=%b mem_req=%b want 0 0", dp_we, mem_req);
    end
    @(negedge CLK);
    mem_ack = 0;
    #1;
    vectors++;
    if (cpu_ready !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_ack: got ready=%b mem_req=%b want 0 0", cpu_ready, mem_req);
    end
    @(negedge CLK);
  endtask

  task automatic test_fill_and_hit();
    bm[32'h0000_1004] = 32'hDEAD_BEEF;
    fm[32'h0000_1004] = 32'hDEAD_BEEF;
    run_access(0, 32'h0000_1004, '0, 2);
    vectors++;
    if (!(a_valid[0][11'h401] && !a_dirty[0][11'h401] && a_data[0][11'h401] == 32'hDEAD_BEEF)) begin
      miscompares++;
      $display("FAIL first_fill: got valid=%b dirty=%b data=%h want 1 0 deadbeef",
               a_valid[0][11'h401], a_dirty[0][11'h401], a_data[0][11'h401]);
    end
    run_access(0, 32'h0000_3004, '0, 1);
    run_access(0, 32'h0000_1004, '0, 0);
  endtask

  task automatic test_store_hit();
    run_access(1, 32'h0000_1004, 32'h5555_5555, 0);
    run_access(0, 32'h0000_5004, '0, 1);
    vectors++;
    if (a_tag[1][11'h401] !== 19'd2) begin
      miscompares++;
      $display("FAIL clean_victim: got way1 tag=%h want 2", a_tag[1][11'h401]);
    end
  endtask

  task automatic test_writeback();
    run_access(0, 32'h0000_7004, '0, 2);
    vectors++;
    if (bm_rd(32'h0000_1004) !== 32'h5555_5555) begin
      miscompares++;
      $display("FAIL writeback_mem: got %h want 55555555", bm_rd(32'h0000_1004));
    end
  endtask

  task automatic test_reset_mid_refill();
    line_t ent;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_9008; cpu_wdata = '0;
    #1;
    for (int n = 0; n < 20 && !mem_req; n++) begin
      @(negedge CLK);
      #1;
    end
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_9008) begin
      miscompares++;
      $display("FAIL refill_start: got req=%b we=%b addr=%h want 1 0 00009008", mem_req, mem_we, mem_addr);
    end
    @(negedge CLK);
    RESET = 1; cpu_req = 0;
    @(negedge CLK);
    RESET = 0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || cpu_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort: got req=%b we=%b addr=%h ready=%b want 0 0 0 0",
               mem_req, mem_we, mem_addr, cpu_ready);
    end
    mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    vectors++;
    if (dp_we !== 1'b0) begin
      miscompares++;
      $display("FAIL late_ack: got dp_we=%b want 0", dp_we);
    end
    @(negedge CLK);
    mem_ack = 0;
    #1;
    vectors++;
    if (dp_we !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL after_late_ack: got dp_we=%b mem_req=%b want 0 0", dp_we, mem_req);
    end
    // Cleared LRU state makes way0 the eviction candidate in every full set.
    for (int s = 0; s < 2048; s++)
      if (rset[s].size() == 2 && rset[s][1].way == 1'b1) begin
        ent = rset[s][1];
        rset[s].delete(1);
        rset[s].push_front(ent);
      end
    @(negedge CLK);
  endtask

  task automatic test_lru_after_reset();
    run_access(0, 32'h0000_B004, '0, 1);
    vectors++;
    if (a_tag[0][11'h401] !== 19'd5 || a_tag[1][11'h401] !== 19'd2) begin
      miscompares++;
      $display("FAIL lru_reset: got way0 tag=%h way1 tag=%h want 5 2", a_tag[0][11'h401], a_tag[1][11'h401]);
    end
  endtask

  task automatic test_ack_stall();
    run_access(0, 32'h0004_0010, '0, 10);
    run_access(1, 32'h0008_0010, 32'h1234_5678, 10);
    run_access(0, 32'h000C_0010, '0, 10);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      run_access(1, {19'd40 + 19'(i % 3), 11'd9, 2'b00}, d, i % 3);
      run_access(0, {19'd40 + 19'(i % 3), 11'd9, 2'b00}, '0, 0);
    end
  endtask

  task automatic test_random();
    logic [18:0] t;
    logic [10:0] ix;
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      t = 19'($urandom_range(0, 4)) + 19'd100;
      ix = 11'($urandom_range(16, 19));
      a = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF_FFFC) : {t, ix, 2'b00};
      run_access($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_fill_and_hit();
    test_store_hit();
    test_writeback();
    test_reset_mid_refill();
    test_lru_after_reset();
    test_ack_stall();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test want finish before 500000");
    $fatal(1);
  end
endmodule
